// File: rtl/v2_pulse_gen.sv
// ---------------------------------------------------------------------------
// v2_pulse_gen -- detector-pulse emulator feeding the v2 trapezoidal filter.
//
// On an accepted trigger the block synthesises a linear rise of
// 2^RISE_SHIFT clocks up to the captured amplitude, then an exponential
// decay p <= p - (p >> TAU_SHIFT) (finishing with unit steps below
// 2^TAU_SHIFT), all on top of a constant BASELINE.
//
// Optional feature (macro V2_PULSE_PILEUP_EN):
//   defined   -> a trigger during DECAY is accepted and the new pulse rises
//                on top of the current tail (pile-up emulation).
//   undefined -> triggers during DECAY are counted as misses.
//
// Ports:
//   clk_i        sample clock
//   reset_i      asynchronous, active-low reset
//   trig_i       pulse request, sampled on rising clk_i
//   amp_i        pulse amplitude, captured when the trigger is accepted
//   trig_ack_o   one-cycle pulse: trigger accepted
//   busy_o       high while a pulse is in progress (state != IDLE)
//   out_o        registered sample stream, min(BASELINE + p, 2^WIDTH - 1)
//   miss_cnt_o   saturating count of rejected triggers
// ---------------------------------------------------------------------------
module v2_pulse_gen #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned RISE_SHIFT = 2,
  parameter int unsigned TAU_SHIFT  = 5,
  parameter int unsigned BASELINE   = 0
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             trig_i,
  input  logic [WIDTH-1:0] amp_i,
  output logic             trig_ack_o,
  output logic             busy_o,
  output logic [WIDTH-1:0] out_o,
  output logic [7:0]       miss_cnt_o
);

  // Accumulator is one bit wider than the sample; sums are formed in SW bits
  // so neither base + a nor BASELINE + p can wrap before clamping.
  localparam int unsigned PW = WIDTH + 1;
  localparam int unsigned CW = (RISE_SHIFT > 0) ? RISE_SHIFT : 1;
  localparam int unsigned SW = WIDTH + CW + 2;

  localparam logic [SW-1:0]    MAX_S      = {{(SW-WIDTH){1'b0}}, {WIDTH{1'b1}}};
  localparam logic [SW-1:0]    BASE_S     = SW'(BASELINE);
  localparam logic [WIDTH-1:0] OUT_RST    = (BASE_S > MAX_S) ? {WIDTH{1'b1}} : BASE_S[WIDTH-1:0];
  localparam logic [PW-1:0]    P_ZERO     = {PW{1'b0}};
  localparam logic [PW-1:0]    P_ONE      = PW'(1'b1);
  localparam logic [PW-1:0]    DECAY_KNEE = {{(PW-1){1'b0}}, 1'b1} << TAU_SHIFT;
  localparam logic [CW-1:0]    CNT_ZERO   = {CW{1'b0}};
  localparam logic [CW-1:0]    CNT_ONE    = CW'(1'b1);
  localparam logic [CW-1:0]    CNT_LAST   = CW'((32'd1 << RISE_SHIFT) - 32'd1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RISE  = 2'd1,
    S_DECAY = 2'd2
  } state_t;

  // Clamp a wide sum to the largest WIDTH-bit sample value.
  function automatic logic [WIDTH-1:0] clamp_out(input logic [SW-1:0] v);
    logic [WIDTH-1:0] r;
    if (v > MAX_S) begin
      r = {WIDTH{1'b1}};
    end else begin
      r = v[WIDTH-1:0];
    end
    return r;
  endfunction

  // Same clamp, widened to the accumulator width.
  function automatic logic [PW-1:0] clamp_p(input logic [SW-1:0] v);
    return {1'b0, clamp_out(v)};
  endfunction

  state_t           state_q, state_d;
  logic [PW-1:0]    p_q, p_d;
  logic [PW-1:0]    base_q, base_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] step_q, step_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             ack_q, ack_d;
  logic             busy_q, busy_d;
  logic [7:0]       miss_q, miss_d;

  logic             accept_s;
  logic             reject_s;
  logic [PW-1:0]    rise_step_s;
  logic [PW-1:0]    rise_last_s;
  logic [PW-1:0]    decay_s;

  // Candidate accumulator values for the rise and decay phases.
  always_comb begin
    rise_step_s = clamp_p(SW'(base_q) + SW'(step_q) * (SW'(cnt_q) + SW'(CNT_ONE)));
    // Final rise sample uses the full amplitude so truncated low bits return.
    rise_last_s = clamp_p(SW'(base_q) + SW'(a_q));
    decay_s     = p_q - (p_q >> TAU_SHIFT);
  end

  // Next-state, accumulator and output logic.
  always_comb begin
    state_d  = state_q;
    p_d      = p_q;
    base_d   = base_q;
    a_d      = a_q;
    step_d   = step_q;
    cnt_d    = cnt_q;
    accept_s = 1'b0;
    reject_s = 1'b0;

    case (state_q)
      S_IDLE: begin
        accept_s = trig_i;
      end
      S_RISE: begin
        cnt_d    = cnt_q + CNT_ONE;
        reject_s = trig_i;
        if (cnt_q == CNT_LAST) begin
          p_d     = rise_last_s;
          state_d = S_DECAY;
        end else begin
          p_d     = rise_step_s;
          state_d = S_RISE;
        end
      end
      S_DECAY: begin
        // Below the knee the shift term is zero, so finish with unit steps.
        if (p_q >= DECAY_KNEE) begin
          p_d = decay_s;
        end else if (p_q != P_ZERO) begin
          p_d = p_q - P_ONE;
        end else begin
          p_d = p_q;
        end
        if (p_q == P_ZERO) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DECAY;
        end
`ifdef V2_PULSE_PILEUP_EN
        accept_s = trig_i;
`else
        reject_s = trig_i;
`endif
      end
      default: begin
        state_d = S_IDLE;
        p_d     = P_ZERO;
      end
    endcase

    // Acceptance holds p for this edge; the new rise is built on top of it.
    if (accept_s) begin
      a_d     = amp_i;
      step_d  = amp_i >> RISE_SHIFT;
      base_d  = p_q;
      cnt_d   = CNT_ZERO;
      p_d     = p_q;
      state_d = S_RISE;
    end else begin
      a_d = a_d;
    end

    if (reject_s && (miss_q != 8'hFF)) begin
      miss_d = miss_q + 8'd1;
    end else begin
      miss_d = miss_q;
    end

    ack_d  = accept_s;
    busy_d = (state_d != S_IDLE);
    out_d  = clamp_out(BASE_S + SW'(p_d));
  end

  // State, datapath and output registers.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= S_IDLE;
      p_q     <= P_ZERO;
      base_q  <= P_ZERO;
      a_q     <= {WIDTH{1'b0}};
      step_q  <= {WIDTH{1'b0}};
      cnt_q   <= CNT_ZERO;
      out_q   <= OUT_RST;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      miss_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      base_q  <= base_d;
      a_q     <= a_d;
      step_q  <= step_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      miss_q  <= miss_d;
    end
  end

  assign trig_ack_o = ack_q;
  assign busy_o     = busy_q;
  assign out_o      = out_q;
  assign miss_cnt_o = miss_q;

endmodule

// File: tb/tb_v2_pulse_gen.sv
// ---------------------------------------------------------------------------
// tb_v2_pulse_gen -- directed self-checking bench for v2_pulse_gen.
// u_dut uses default parameters; u_dut_sat uses BASELINE = 65000 to exercise
// output clamping. Pile-up expectations follow V2_PULSE_PILEUP_EN.
// ---------------------------------------------------------------------------
module tb_v2_pulse_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic        trig, trig_b;
  logic [15:0] amp, amp_b;
  logic        ack, busy, ack_b, busy_b;
  logic [15:0] out, out_b;
  logic [7:0]  miss, miss_b;

  int n_tests = 0;
  int n_fail  = 0;

  // 10-time-unit sample clock.
  always #5 clk = ~clk;

  v2_pulse_gen u_dut (
    .clk_i(clk), .reset_i(reset), .trig_i(trig), .amp_i(amp),
    .trig_ack_o(ack), .busy_o(busy), .out_o(out), .miss_cnt_o(miss)
  );

  v2_pulse_gen #(.BASELINE(65000)) u_dut_sat (
    .clk_i(clk), .reset_i(reset), .trig_i(trig_b), .amp_i(amp_b),
    .trig_ack_o(ack_b), .busy_o(busy_b), .out_o(out_b), .miss_cnt_o(miss_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int decay_model(input int p);
    if (p >= 32) return p - (p >> 5);
    else if (p != 0) return p - 1;
    else return 0;
  endfunction

  task automatic wait_idle();
    for (int i = 0; i < 1000; i++) begin
      if (busy == 1'b0) break;
      tick();
    end
    check_eq("idle_wait", 32'(busy), 32'd0);
  endtask

  // Watchdog: never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e;
    int acks;
    reset = 1'b1; trig = 1'b0; amp = 16'd0; trig_b = 1'b0; amp_b = 16'd0;
    #3 reset = 1'b0;
    #1;
    check_eq("rst_out",    32'(out),   32'd0);
    check_eq("rst_busy",   32'(busy),  32'd0);
    check_eq("rst_ack",    32'(ack),   32'd0);
    check_eq("rst_miss",   32'(miss),  32'd0);
    check_eq("rst_out_b",  32'(out_b), 32'd65000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    tick();

    // Basic pulse, amp = 1024.
    amp = 16'd1024; trig = 1'b1; tick();
    check_eq("basic_ack",  32'(ack),  32'd1);
    check_eq("basic_busy", 32'(busy), 32'd1);
    check_eq("basic_out0", 32'(out),  32'd0);
    trig = 1'b0;
    tick(); check_eq("basic_rise1", 32'(out), 32'd256);
    check_eq("basic_ack_drop", 32'(ack), 32'd0);
    tick(); check_eq("basic_rise2", 32'(out), 32'd512);
    tick(); check_eq("basic_rise3", 32'(out), 32'd768);
    tick(); check_eq("basic_rise4", 32'(out), 32'd1024);
    tick(); check_eq("basic_dec1",  32'(out), 32'd992);
    tick(); check_eq("basic_dec2",  32'(out), 32'd961);
    tick(); check_eq("basic_dec3",  32'(out), 32'd931);
    e = 931;
    for (int i = 0; i < 400; i++) begin
      tick();
      e = decay_model(e);
      check_eq("basic_decay", 32'(out), 32'(e));
      if (e == 0) break;
    end
    check_eq("basic_busy_tail", 32'(busy), 32'd1);
    tick();
    check_eq("basic_busy_fall", 32'(busy), 32'd0);
    check_eq("basic_out_end",   32'(out),  32'd0);

    // Non-divisible amplitude.
    amp = 16'd1023; trig = 1'b1; tick(); trig = 1'b0;
    tick(); check_eq("nd_rise1", 32'(out), 32'd255);
    tick(); check_eq("nd_rise2", 32'(out), 32'd510);
    tick(); check_eq("nd_rise3", 32'(out), 32'd765);
    tick(); check_eq("nd_rise4", 32'(out), 32'd1023);
    wait_idle();

`ifndef V2_PULSE_PILEUP_EN
    // Miss counting during DECAY.
    amp = 16'd1024; trig = 1'b1; tick();
    check_eq("miss_pulse_ack", 32'(ack), 32'd1);
    trig = 1'b0;
    repeat (4) tick();
    check_eq("miss_peak", 32'(out), 32'd1024);
    tick(); check_eq("miss_dec1", 32'(out), 32'd992);
    trig = 1'b1; tick();
    check_eq("miss_ack",  32'(ack),  32'd0);
    check_eq("miss_cnt1", 32'(miss), 32'd1);
    check_eq("miss_out",  32'(out),  32'd961);
    e = 961;
    for (int i = 0; i < 10; i++) begin
      tick();
      e = decay_model(e);
    end
    check_eq("miss_cnt11",  32'(miss), 32'd11);
    check_eq("miss_out11",  32'(out),  32'(e));
    check_eq("miss_ack11",  32'(ack),  32'd0);
    acks = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (ack) acks++;
    end
    check_eq("miss_sat", 32'(miss), 32'd255);
    check_eq("held_reaccept", 32'(acks > 0), 32'd1);
    trig = 1'b0;
    wait_idle();
`else
    // Pile-up on the decaying tail.
    amp = 16'd800; trig = 1'b1; tick();
    check_eq("pile_ack1", 32'(ack), 32'd1);
    trig = 1'b0;
    tick(); check_eq("pile_r1", 32'(out), 32'd200);
    tick(); check_eq("pile_r2", 32'(out), 32'd400);
    tick(); check_eq("pile_r3", 32'(out), 32'd600);
    tick(); check_eq("pile_r4", 32'(out), 32'd800);
    amp = 16'd512; trig = 1'b1; tick();
    check_eq("pile_ack2",  32'(ack),  32'd1);
    check_eq("pile_hold",  32'(out),  32'd800);
    check_eq("pile_miss0", 32'(miss), 32'd0);
    trig = 1'b0;
    tick(); check_eq("pile_s1", 32'(out), 32'd928);
    tick(); check_eq("pile_s2", 32'(out), 32'd1056);
    tick(); check_eq("pile_s3", 32'(out), 32'd1184);
    tick(); check_eq("pile_s4", 32'(out), 32'd1312);
    tick(); check_eq("pile_dec", 32'(out), 32'd1271);
    wait_idle();
    amp = 16'd1024; trig = 1'b1; tick(); trig = 1'b0;
    tick(); check_eq("pile_rise_r1", 32'(out), 32'd256);
    trig = 1'b1; tick();
    check_eq("pile_rise_out",  32'(out),  32'd512);
    check_eq("pile_rise_ack",  32'(ack),  32'd0);
    check_eq("pile_rise_miss", 32'(miss), 32'd1);
    trig = 1'b0;
    wait_idle();
`endif

    // Reset mid-rise.
    amp = 16'd1024; trig = 1'b1; tick(); trig = 1'b0;
    tick(); check_eq("mr_rise1", 32'(out), 32'd256);
    tick(); check_eq("mr_rise2", 32'(out), 32'd512);
    #2 reset = 1'b0;
    #1;
    check_eq("mr_out",   32'(out),   32'd0);
    check_eq("mr_busy",  32'(busy),  32'd0);
    check_eq("mr_ack",   32'(ack),   32'd0);
    check_eq("mr_miss",  32'(miss),  32'd0);
    check_eq("mr_out_b", 32'(out_b), 32'd65000);
    #1 reset = 1'b1;
    tick();
    check_eq("mr_no_residual", 32'(out),  32'd0);
    check_eq("mr_idle",        32'(busy), 32'd0);
    amp = 16'd1024; trig = 1'b1; tick();
    check_eq("mr_new_ack", 32'(ack), 32'd1);
    trig = 1'b0;
    tick(); check_eq("mr_new1", 32'(out), 32'd256);
    tick(); check_eq("mr_new2", 32'(out), 32'd512);
    tick(); check_eq("mr_new3", 32'(out), 32'd768);
    tick(); check_eq("mr_new4", 32'(out), 32'd1024);
    wait_idle();

    // amp = 0, with a trigger coinciding with the final DECAY edge.
    amp = 16'd0; trig = 1'b1; tick();
    check_eq("zero_ack",  32'(ack),  32'd1);
    check_eq("zero_busy", 32'(busy), 32'd1);
    trig = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("zero_rise", 32'(out), 32'd0);
    end
    check_eq("zero_busy_decay", 32'(busy), 32'd1);
    trig = 1'b1; tick();
`ifndef V2_PULSE_PILEUP_EN
    check_eq("zero_idle",       32'(busy), 32'd0);
    check_eq("zero_coinc_ack",  32'(ack),  32'd0);
    check_eq("zero_coinc_miss", 32'(miss), 32'd1);
    tick();
    check_eq("zero_reaccept", 32'(ack), 32'd1);
`else
    check_eq("zero_coinc_ack",  32'(ack),  32'd1);
    check_eq("zero_coinc_busy", 32'(busy), 32'd1);
    check_eq("zero_coinc_miss", 32'(miss), 32'd0);
`endif
    trig = 1'b0;
    wait_idle();

    // Output saturation with BASELINE = 65000.
    amp_b = 16'd1000; trig_b = 1'b1; tick();
    check_eq("sat_ack", 32'(ack_b), 32'd1);
    trig_b = 1'b0;
    tick(); check_eq("sat_r1", 32'(out_b), 32'd65250);
    tick(); check_eq("sat_r2", 32'(out_b), 32'd65500);
    tick(); check_eq("sat_r3", 32'(out_b), 32'd65535);
    tick(); check_eq("sat_r4", 32'(out_b), 32'd65535);
    tick(); check_eq("sat_dec", 32'(out_b), 32'd65535);
    check_eq("sat_busy", 32'(busy_b), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
